// File: rtl/serv_timer_if.sv
// Wishbone slave bus for the SERV machine timer.
// Signal names keep the serv_top point of view: i_* are driven by the
// bus master, o_* by the timer.
//   i_wb_adr [3:0]  byte address, only [3:2] decoded
//   i_wb_dat [31:0] write data
//   i_wb_sel [3:0]  write byte enables
//   i_wb_we         1=write 0=read
//   i_wb_cyc        request valid, held until o_wb_ack
//   o_wb_rdt [31:0] read data, valid with o_wb_ack
//   o_wb_ack        single-cycle acknowledge
interface serv_timer_if;
  logic [3:0]  i_wb_adr;
  logic [31:0] i_wb_dat;
  logic [3:0]  i_wb_sel;
  logic        i_wb_we;
  logic        i_wb_cyc;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;

  modport master (
    output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc,
    input  o_wb_rdt, o_wb_ack
  );

  modport slave (
    input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc,
    output o_wb_rdt, o_wb_ack
  );
endinterface

// File: rtl/serv_timer.sv
// Machine timer for SERV: 64-bit mtime counter advanced by a prescaler,
// 64-bit mtimecmp compare register, level interrupt while mtime >= mtimecmp.
//   clk    clock, rising edge
//   i_rst  synchronous active-high reset
//   wb     Wishbone slave (serv_timer_if.slave)
//            word 0 mtime_lo, 1 mtime_hi, 2 mtimecmp_lo, 3 mtimecmp_hi
//   o_irq  registered timer interrupt request
module serv_timer #(
  parameter int unsigned PRESCALE  = 1,
  parameter logic [63:0] RESET_CMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        i_rst,
  serv_timer_if.slave wb,
  output logic        o_irq
);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  state_t      state;
  logic [15:0] pre_cnt;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [31:0] hi_shadow;

  logic        tick;
  logic        accept;
  logic        wr_en;
  logic [1:0]  word;
  logic [63:0] mtime_nxt;
  logic [63:0] cmp_nxt;
  logic [31:0] rd_data;

  // Byte address bits [1:0] are intentionally ignored.
  logic        unused_adr;
  assign unused_adr = ^wb.i_wb_adr[1:0];

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  assign tick   = (pre_cnt == PRE_MAX);
  assign accept = (state == S_IDLE) && wb.i_wb_cyc;
  assign wr_en  = accept && wb.i_wb_we && (wb.i_wb_sel != 4'b0000);
  assign word   = wb.i_wb_adr[3:2];

  // A write to an mtime half replaces the increment for that edge: the
  // written half takes the new bytes and everything else keeps its
  // pre-increment value, so no carry crosses halves.
  always_comb begin
    mtime_nxt = tick ? mtime + 64'd1 : mtime;
    cmp_nxt   = mtimecmp;
    if (wr_en) begin
      case (word)
        2'd0:    mtime_nxt = {mtime[63:32],
                              merge_bytes(mtime[31:0], wb.i_wb_dat, wb.i_wb_sel)};
        2'd1:    mtime_nxt = {merge_bytes(mtime[63:32], wb.i_wb_dat, wb.i_wb_sel),
                              mtime[31:0]};
        2'd2:    cmp_nxt[31:0]  = merge_bytes(mtimecmp[31:0], wb.i_wb_dat, wb.i_wb_sel);
        default: cmp_nxt[63:32] = merge_bytes(mtimecmp[63:32], wb.i_wb_dat, wb.i_wb_sel);
      endcase
    end
  end

  // mtime_hi reads the shadow captured by the last mtime_lo read so a
  // lo-then-hi pair sees one consistent 64-bit value.
  always_comb begin
    case (word)
      2'd0:    rd_data = mtime[31:0];
      2'd1:    rd_data = hi_shadow;
      2'd2:    rd_data = mtimecmp[31:0];
      default: rd_data = mtimecmp[63:32];
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      pre_cnt      <= 16'd0;
      mtime        <= 64'd0;
      mtimecmp     <= RESET_CMP;
      hi_shadow    <= 32'd0;
      wb.o_wb_ack  <= 1'b0;
      wb.o_wb_rdt  <= 32'd0;
      o_irq        <= 1'b0;
    end else begin
      pre_cnt  <= tick ? 16'd0 : pre_cnt + 16'd1;
      mtime    <= mtime_nxt;
      mtimecmp <= cmp_nxt;
      // Compare uses current register values, so o_irq trails them by one cycle.
      o_irq    <= (mtime >= mtimecmp);

      case (state)
        S_IDLE: begin
          wb.o_wb_ack <= 1'b0;
          wb.o_wb_rdt <= 32'd0;
          if (wb.i_wb_cyc) begin
            state       <= S_ACK;
            wb.o_wb_ack <= 1'b1;
            wb.o_wb_rdt <= wb.i_wb_we ? 32'd0 : rd_data;
            if (!wb.i_wb_we && (word == 2'd0)) hi_shadow <= mtime[63:32];
          end
        end
        default: begin
          // Always return to idle so ack is never high two cycles in a row.
          state       <= S_IDLE;
          wb.o_wb_ack <= 1'b0;
          wb.o_wb_rdt <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serv_timer.sv
// Bench for serv_timer: two instances (PRESCALE=1 and PRESCALE=4) driven by
// the same bus stimulus and compared against a behavioural model.
module tb_serv_timer;

  logic        clk;
  logic        rst;
  logic [3:0]  adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        irq0, irq1;

  int checks = 0;
  int errors = 0;

  serv_timer_if bus0();
  serv_timer_if bus1();

  assign bus0.i_wb_adr = adr;
  assign bus0.i_wb_dat = dat;
  assign bus0.i_wb_sel = sel;
  assign bus0.i_wb_we  = we;
  assign bus0.i_wb_cyc = cyc;
  assign bus1.i_wb_adr = adr;
  assign bus1.i_wb_dat = dat;
  assign bus1.i_wb_sel = sel;
  assign bus1.i_wb_we  = we;
  assign bus1.i_wb_cyc = cyc;

  serv_timer #(.PRESCALE(1)) dut0 (.clk(clk), .i_rst(rst), .wb(bus0.slave), .o_irq(irq0));
  serv_timer #(.PRESCALE(4)) dut1 (.clk(clk), .i_rst(rst), .wb(bus1.slave), .o_irq(irq1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic dut_ack(input int i);
    return (i == 0) ? bus0.o_wb_ack : bus1.o_wb_ack;
  endfunction
  function automatic logic [31:0] dut_rdt(input int i);
    return (i == 0) ? bus0.o_wb_rdt : bus1.o_wb_rdt;
  endfunction
  function automatic logic dut_irq(input int i);
    return (i == 0) ? irq0 : irq1;
  endfunction
  function automatic int unsigned ps_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  // ---------------- reference model ----------------
  // Register file seen as four 32-bit words; mtime advances on every
  // PRESCALE-th clock since reset, a write to a word replaces that edge's
  // increment for the whole counter.
  logic [63:0] m_time [2];
  logic [63:0] m_cmp  [2];
  logic [31:0] m_shadow [2];
  logic [31:0] m_rdt  [2];
  logic        m_ack  [2];
  logic        m_irq  [2];
  int unsigned m_edges [2];
  logic [31:0] mw [4];
  logic [63:0] nx_time, nx_cmp;
  logic        take;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_time[i] = 64'd0; m_cmp[i] = '1; m_shadow[i] = 32'd0;
        m_rdt[i] = 32'd0; m_ack[i] = 1'b0; m_irq[i] = 1'b0; m_edges[i] = 0;
      end else begin
        m_edges[i] = m_edges[i] + 1;
        mw[0] = m_time[i][31:0]; mw[1] = m_time[i][63:32];
        mw[2] = m_cmp[i][31:0];  mw[3] = m_cmp[i][63:32];
        nx_time = ((m_edges[i] % ps_of(i)) == 0) ? m_time[i] + 64'd1 : m_time[i];
        nx_cmp  = m_cmp[i];
        take = cyc && !m_ack[i];
        m_irq[i] = (m_time[i] >= m_cmp[i]);
        m_rdt[i] = 32'd0;
        if (take && we && sel != 4'b0000) begin
          for (int b = 0; b < 4; b++)
            if (sel[b]) mw[adr[3:2]][8*b +: 8] = dat[8*b +: 8];
          if (adr[3:2] < 2) nx_time = {mw[1], mw[0]};
          else              nx_cmp  = {mw[3], mw[2]};
        end else if (take && !we) begin
          if (adr[3:2] == 2'd1) m_rdt[i] = m_shadow[i];
          else                  m_rdt[i] = mw[adr[3:2]];
          if (adr[3:2] == 2'd0) m_shadow[i] = mw[1];
        end
        m_ack[i]  = take;
        m_time[i] = nx_time;
        m_cmp[i]  = nx_cmp;
      end
    end
  end

  // ---------------- drivers ----------------
  logic [31:0] last_rdt  [2];
  logic [31:0] last_mrdt [2];
  logic        last_ack  [2];
  logic        last_irq  [2];

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_access(input logic [3:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0] s);
    adr = a; we = w; dat = d; sel = s; cyc = 1'b1;
    step_clk();
    for (int i = 0; i < 2; i++) begin
      last_rdt[i]  = dut_rdt(i);
      last_mrdt[i] = m_rdt[i];
      last_ack[i]  = dut_ack(i);
      last_irq[i]  = dut_irq(i);
    end
    cyc = 1'b0; we = 1'b0; sel = 4'b0000;
    step_clk();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; cyc = 1'b0; we = 1'b0; adr = 4'h0; dat = 32'h0; sel = 4'h0;
    repeat (3) step_clk();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dut_ack(i) !== 1'b0 || dut_rdt(i) !== 32'd0 || dut_irq(i) !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d] ack=%b rdt=%h irq=%b expected 0/0/0", i, dut_ack(i), dut_rdt(i), dut_irq(i));
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_count();
    repeat (10) begin
      step_clk();
      checks++;
      if (irq0 !== 1'b0) begin
        errors++; $display("FAIL count_irq got %b expected 0", irq0);
      end
    end
    wb_access(4'h0, 1'b0, 32'h0, 4'h0);
    checks++;
    if (last_rdt[0] !== 32'd10) begin
      errors++; $display("FAIL count_lo got %0d expected 10", last_rdt[0]);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (last_ack[i] !== 1'b1 || last_rdt[i] !== last_mrdt[i]) begin
        errors++;
        $display("FAIL count_read[%0d] ack=%b rdt=%h expected 1/%h", i, last_ack[i], last_rdt[i], last_mrdt[i]);
      end
    end
  endtask

  task automatic test_irq_cmp();
    int k;
    bit done;
    wb_access(4'hC, 1'b1, 32'h0, 4'hF);
    wb_access(4'h8, 1'b1, 32'd20, 4'hF);
    k = -1; done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      step_clk();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (dut_irq(i) !== m_irq[i]) begin
          errors++; $display("FAIL irq_track[%0d] got %b expected %b", i, dut_irq(i), m_irq[i]);
        end
      end
      if (k >= 0) begin
        checks++;
        if (irq0 !== 1'b1) begin
          errors++; $display("FAIL irq_rise got %b expected 1 one cycle after mtime=20", irq0);
        end
        done = 1;
      end else if (m_time[0] == 64'd20) begin
        k = c;
        checks++;
        if (irq0 !== 1'b0) begin
          errors++; $display("FAIL irq_early got %b expected 0 when mtime reaches 20", irq0);
        end
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL irq_rise_timeout got no rise expected rise within 100 cycles");
    end
    wb_access(4'h8, 1'b1, 32'hFFFF_FFFF, 4'hF);
    checks++;
    if (last_irq[0] !== 1'b1 || irq0 !== 1'b0) begin
      errors++;
      $display("FAIL irq_fall got %b,%b expected 1,0 after cmp write", last_irq[0], irq0);
    end
  endtask

  task automatic test_carry();
    logic [31:0] exp_lo;
    wb_access(4'h4, 1'b1, 32'h0, 4'hF);
    wb_access(4'h0, 1'b1, 32'hFFFF_FFFE, 4'hF);
    wb_access(4'h0, 1'b0, 32'h0, 4'h0);
    checks++;
    if (last_rdt[0] !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL carry_lo got %h expected FFFFFFFF", last_rdt[0]);
    end
    checks++;
    if (last_rdt[1] !== last_mrdt[1]) begin
      errors++; $display("FAIL carry_lo_p4 got %h expected %h", last_rdt[1], last_mrdt[1]);
    end
    step_clk();
    wb_access(4'h4, 1'b0, 32'h0, 4'h0);
    checks++;
    if (last_rdt[0] !== 32'h0 || m_time[0][63:32] !== 32'd1) begin
      errors++;
      $display("FAIL carry_shadow got %h (live hi %h) expected 0 (live hi 1)", last_rdt[0], m_time[0][63:32]);
    end
    wb_access(4'h0, 1'b0, 32'h0, 4'h0);
    exp_lo = last_mrdt[0];
    checks++;
    if (last_rdt[0] !== exp_lo) begin
      errors++; $display("FAIL carry_lo2 got %h expected %h", last_rdt[0], exp_lo);
    end
    wb_access(4'h4, 1'b0, 32'h0, 4'h0);
    checks++;
    if (last_rdt[0] !== 32'd1) begin
      errors++; $display("FAIL carry_hi got %h expected 1", last_rdt[0]);
    end
    checks++;
    if (last_rdt[1] !== last_mrdt[1]) begin
      errors++; $display("FAIL carry_hi_p4 got %h expected %h", last_rdt[1], last_mrdt[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic prev;
    adr = 4'h8; we = 1'b0; sel = 4'h0; cyc = 1'b1;
    prev = bus0.o_wb_ack;
    checks++;
    if (prev !== 1'b0) begin
      errors++; $display("FAIL b2b_ack0 got %b expected 0", prev);
    end
    for (int k = 1; k < 6; k++) begin
      step_clk();
      checks++;
      if (bus0.o_wb_ack !== logic'(k % 2)) begin
        errors++; $display("FAIL b2b_ack%0d got %b expected %0d", k, bus0.o_wb_ack, k % 2);
      end
      checks++;
      if (prev === 1'b1 && bus0.o_wb_ack === 1'b1) begin
        errors++; $display("FAIL b2b_consecutive got 1,1 expected no consecutive acks");
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (dut_ack(i) !== m_ack[i] || dut_rdt(i) !== m_rdt[i]) begin
          errors++;
          $display("FAIL b2b_model[%0d] ack=%b rdt=%h expected %b/%h", i, dut_ack(i), dut_rdt(i), m_ack[i], m_rdt[i]);
        end
      end
      prev = bus0.o_wb_ack;
    end
    cyc = 1'b0;
    repeat (2) step_clk();
  endtask

  task automatic test_byte_lanes();
    wb_access(4'h8, 1'b1, 32'h1234_5678, 4'b0101);
    wb_access(4'h8, 1'b0, 32'h0, 4'h0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (last_rdt[i] !== 32'hFF34_FF78) begin
        errors++; $display("FAIL byte_lanes[%0d] got %h expected FF34FF78", i, last_rdt[i]);
      end
    end
    wb_access(4'hC, 1'b1, 32'hDEAD_BEEF, 4'b0000);
    checks++;
    if (last_ack[0] !== 1'b1) begin
      errors++; $display("FAIL sel0_ack got %b expected 1", last_ack[0]);
    end
    wb_access(4'hC, 1'b0, 32'h0, 4'h0);
    checks++;
    if (last_rdt[0] !== 32'h0) begin
      errors++; $display("FAIL sel0_nochange got %h expected 0", last_rdt[0]);
    end
  endtask

  task automatic test_prescale();
    logic [31:0] a0, a1;
    wb_access(4'h0, 1'b0, 32'h0, 4'h0);
    a0 = last_rdt[0]; a1 = last_rdt[1];
    repeat (2) step_clk();
    wb_access(4'h0, 1'b0, 32'h0, 4'h0);
    checks++;
    if (last_rdt[0] - a0 !== 32'd4) begin
      errors++; $display("FAIL prescale1 got delta %0d expected 4", last_rdt[0] - a0);
    end
    checks++;
    if (last_rdt[1] - a1 !== 32'd1) begin
      errors++; $display("FAIL prescale4 got delta %0d expected 1", last_rdt[1] - a1);
    end
  endtask

  task automatic test_reset_mid();
    adr = 4'h8; we = 1'b1; dat = 32'h0; sel = 4'hF; cyc = 1'b1; rst = 1'b1;
    step_clk();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dut_ack(i) !== 1'b0) begin
        errors++; $display("FAIL rst_mid_ack[%0d] got %b expected 0", i, dut_ack(i));
      end
    end
    cyc = 1'b0; we = 1'b0;
    step_clk();
    rst = 1'b0;
    wb_access(4'h0, 1'b0, 32'h0, 4'h0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (last_rdt[i] !== 32'h0) begin
        errors++; $display("FAIL rst_mid_mtime[%0d] got %h expected 0", i, last_rdt[i]);
      end
    end
    wb_access(4'h8, 1'b0, 32'h0, 4'h0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (last_rdt[i] !== 32'hFFFF_FFFF) begin
        errors++; $display("FAIL rst_mid_cmp[%0d] got %h expected FFFFFFFF", i, last_rdt[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      if (!cyc || bus0.o_wb_ack) begin
        cyc = ($urandom_range(0, 3) != 0);
        adr = 4'($urandom_range(0, 15));
        we  = 1'($urandom_range(0, 1));
        sel = 4'($urandom_range(0, 15));
        // Keep the high halves small so mtime/mtimecmp ordering flips often.
        dat = adr[2] ? 32'($urandom_range(0, 2)) : $urandom;
      end
      step_clk();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (dut_ack(i) !== m_ack[i] || dut_rdt(i) !== m_rdt[i] || dut_irq(i) !== m_irq[i]) begin
          errors++;
          $display("FAIL random[%0d] n=%0d ack/rdt/irq=%b/%h/%b expected %b/%h/%b", i, n,
                   dut_ack(i), dut_rdt(i), dut_irq(i), m_ack[i], m_rdt[i], m_irq[i]);
        end
      end
    end
    cyc = 1'b0;
    repeat (2) step_clk();
  endtask

  initial begin
    test_reset();
    test_count();
    test_irq_cmp();
    test_carry();
    test_back_to_back();
    test_byte_lanes();
    test_prescale();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
